// File: rtl/ultrasonido_ctrl.sv
// Ultrasonic ranging controller: trigger pulse, echo timing via gated 1 cm tick divider.
// Optional ULTRASONIDO_AVG_EN: distance is the running mean of the last four valid results.
module ultrasonido_ctrl #(
  parameter int unsigned TRIG_CYCLES      = 1000,
  parameter int unsigned ECHO_WAIT_CYCLES = 3000000,
  parameter int unsigned MAX_CM           = 400,
  parameter int unsigned HOLDOFF_CYCLES   = 6000000,
  parameter int unsigned DIST_W           = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              echo,
  input  logic              tick_clk,
  output logic              trigger,
  output logic              div_enable,
  output logic [DIST_W-1:0] distance,
  output logic              valid,
  output logic              timeout,
  output logic              busy
);

  localparam int unsigned CycMax0 =
      (TRIG_CYCLES > ECHO_WAIT_CYCLES) ? TRIG_CYCLES : ECHO_WAIT_CYCLES;
  localparam int unsigned CycMax  = (CycMax0 > HOLDOFF_CYCLES) ? CycMax0 : HOLDOFF_CYCLES;
  localparam int unsigned CntW    = (CycMax > 1) ? $clog2(CycMax) : 1;
  localparam int unsigned TickW   = $clog2(MAX_CM + 1);

  localparam logic [CntW-1:0]  TrigLast = CntW'(TRIG_CYCLES - 1);
  localparam logic [CntW-1:0]  WaitLast = CntW'(ECHO_WAIT_CYCLES - 1);
  localparam logic [CntW-1:0]  HoldLast = CntW'(HOLDOFF_CYCLES - 1);
  localparam logic [TickW-1:0] MaxTick  = TickW'(MAX_CM);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitEcho,
    StMeasure,
    StHoldoff
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d, tick_next;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             load;
  logic [DIST_W-1:0] raw_result, dist_new, distance_q;

  logic echo_s1, echo_s2, echo_d;
  logic tick_s1, tick_s2, tick_d;
  logic echo_rise, echo_fall, tick_rise;

  // Two-flop synchronisers plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_d  <= 1'b0;
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_d  <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
      tick_s1 <= tick_clk;
      tick_s2 <= tick_s1;
      tick_d  <= tick_s2;
    end
  end

  assign echo_rise = echo_s2 & ~echo_d;
  assign echo_fall = ~echo_s2 & echo_d;
  assign tick_rise = tick_s2 & ~tick_d;

  // Saturating count including any tick seen this cycle.
  assign tick_next  = (tick_rise && (tick_cnt_q != MaxTick)) ? tick_cnt_q + TickW'(1)
                                                            : tick_cnt_q;
  assign raw_result = DIST_W'(tick_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cyc_cnt_q  <= '0;
      tick_cnt_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_cnt_q  <= cyc_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_cnt_d  = '0;
    tick_cnt_d = tick_cnt_q;
    load       = 1'b0;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StTrig;
        end
      end
      StTrig: begin
        if (cyc_cnt_q == TrigLast) begin
          state_d = StWaitEcho;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CntW'(1);
        end
      end
      StWaitEcho: begin
        if (echo_rise) begin
          state_d    = StMeasure;
          tick_cnt_d = '0;
        end else if (cyc_cnt_q == WaitLast) begin
          state_d   = StHoldoff;
          timeout_d = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CntW'(1);
        end
      end
      StMeasure: begin
        tick_cnt_d = tick_next;
        // Out-of-range wins over a simultaneous echo fall.
        if (tick_next == MaxTick) begin
          state_d   = StHoldoff;
          timeout_d = 1'b1;
        end else if (echo_fall) begin
          state_d = StHoldoff;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      StHoldoff: begin
        if (cyc_cnt_q == HoldLast) begin
          state_d = StIdle;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef ULTRASONIDO_AVG_EN
  // Three held results plus the incoming one form the 4-deep averaging window.
  logic [DIST_W-1:0] hist_q [3];
  logic [1:0]        nres_q;
  logic [DIST_W+1:0] avg_sum;

  assign avg_sum = {2'b00, raw_result} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
                 + {2'b00, hist_q[2]};
  assign dist_new = (nres_q == 2'd3) ? DIST_W'(avg_sum >> 2) : raw_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q[0] <= '0;
      hist_q[1] <= '0;
      hist_q[2] <= '0;
      nres_q    <= '0;
    end else if (load) begin
      hist_q[0] <= raw_result;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
      if (nres_q != 2'd3) begin
        nres_q <= nres_q + 2'd1;
      end
    end
  end
`else
  assign dist_new = raw_result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      distance_q <= '0;
    end else if (load) begin
      distance_q <= dist_new;
    end
  end

  assign trigger    = (state_q == StTrig);
  assign div_enable = (state_q == StMeasure);
  assign busy       = (state_q != StIdle);
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign distance   = distance_q;

endmodule

// File: tb/tb_ultrasonido_ctrl.sv
// Directed bench for ultrasonido_ctrl with scaled-down timing parameters.
// Tick edges are driven by the bench so every distance is exact.
module tb_ultrasonido_ctrl;

  localparam int unsigned TrigC = 10;
  localparam int unsigned WaitC = 200;
  localparam int unsigned MaxCm = 60;
  localparam int unsigned HoldC = 50;
  localparam int unsigned DistW = 6;

  logic             clk, rst_n, start, echo, tick_clk;
  logic             trigger, div_enable, valid, timeout, busy;
  logic [DistW-1:0] distance;

  int checks, errors, seen_valid, seen_timeout;
  int n;

  ultrasonido_ctrl #(
    .TRIG_CYCLES     (TrigC),
    .ECHO_WAIT_CYCLES(WaitC),
    .MAX_CM          (MaxCm),
    .HOLDOFF_CYCLES  (HoldC),
    .DIST_W          (DistW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .echo      (echo),
    .tick_clk  (tick_clk),
    .trigger   (trigger),
    .div_enable(div_enable),
    .distance  (distance),
    .valid     (valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to following negedges, noting any strobes seen.
  task automatic step(input int cyc);
    repeat (cyc) begin
      @(negedge clk);
      if (valid === 1'b1) seen_valid++;
      if (timeout === 1'b1) seen_timeout++;
    end
  endtask

  task automatic tick_train(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      tick_clk = 1'b1;
      step(4);
      tick_clk = 1'b0;
      step(4);
    end
  endtask

  // Called on the first cycle trigger is high; returns on the first echo-wait cycle.
  task automatic trig_width();
    int w;
    w = 0;
    while (trigger === 1'b1 && w < 100) begin
      w++;
      step(1);
    end
    check("trig_width", w, TrigC);
    check("busy_wait", busy, 1);
  endtask

  task automatic begin_meas();
    start = 1'b1;
    step(1);
    start = 1'b0;
    trig_width();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy === 1'b1 && g < 2000) begin
      g++;
      step(1);
    end
    check("back_idle", busy, 0);
  endtask

  task automatic echo_pulse(input int pre, input bit combined, input int exp);
    step(5);
    echo = 1'b1;
    step(2);
    check("den_before", div_enable, 0);
    step(1);
    check("den_rise3", div_enable, 1);
    tick_train(pre);
    if (combined) tick_clk = 1'b1;
    echo = 1'b0;
    step(2);
    check("den_hold", div_enable, 1);
    check("no_early_valid", valid, 0);
    step(1);
    check("valid_pulse", valid, 1);
    check("no_timeout", timeout, 0);
    check("distance", distance, exp);
    check("den_fall3", div_enable, 0);
    step(1);
    check("valid_1cyc", valid, 0);
    tick_clk = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    seen_valid = 0;
    seen_timeout = 0;
    rst_n = 1'b0;
    start = 1'b1;
    echo = 1'b0;
    tick_clk = 1'b0;
    step(3);
    check("rst_trigger", trigger, 0);
    check("rst_den", div_enable, 0);
    check("rst_valid", valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_distance", distance, 0);

    // start held through reset launches the first measurement.
    rst_n = 1'b1;
    step(1);
    start = 1'b0;
    trig_width();
    echo_pulse(20, 1'b0, 20);
    wait_idle();

    // No echo: timeout latency, distance kept, holdoff length.
    seen_valid = 0;
    begin_meas();
    n = 0;
    while (timeout !== 1'b1 && n < 1000) begin
      step(1);
      n++;
    end
    check("to_latency", n, WaitC);
    check("to_distance", distance, 20);
    check("to_no_valid", seen_valid, 0);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      step(1);
    end
    check("holdoff_len", n, HoldC);
    step(1);
    check("to_1cyc", seen_timeout, 1);

    // Tick coinciding with echo fall is counted.
    begin_meas();
    echo_pulse(14, 1'b1, 15);
    wait_idle();

    // One below the range limit.
    begin_meas();
    echo_pulse(MaxCm - 1, 1'b0, MaxCm - 1);
    wait_idle();

    // Echo held high: out-of-range timeout, no valid.
    begin_meas();
    seen_valid = 0;
    seen_timeout = 0;
    step(5);
    echo = 1'b1;
    step(4);
    tick_train(MaxCm);
    step(4);
    check("oor_timeout", seen_timeout, 1);
    check("oor_no_valid", seen_valid, 0);
    check("oor_distance", distance, MaxCm - 1);
    echo = 1'b0;
    wait_idle();

    // Limit reached on the same cycle as echo fall: timeout wins.
    begin_meas();
    seen_valid = 0;
    seen_timeout = 0;
    step(5);
    echo = 1'b1;
    step(4);
    tick_train(MaxCm - 1);
    tick_clk = 1'b1;
    echo = 1'b0;
    step(6);
    tick_clk = 1'b0;
    check("prio_timeout", seen_timeout, 1);
    check("prio_no_valid", seen_valid, 0);
    check("prio_distance", distance, MaxCm - 1);
    wait_idle();

    // Reset in the middle of a measurement.
    begin_meas();
    step(5);
    echo = 1'b1;
    step(4);
    tick_train(3);
    check("mid_den", div_enable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_trigger", trigger, 0);
    check("mr_den", div_enable, 0);
    check("mr_busy", busy, 0);
    check("mr_distance", distance, 0);
    check("mr_valid", valid, 0);
    check("mr_timeout", timeout, 0);
    echo = 1'b0;
    step(2);
    rst_n = 1'b1;
    seen_valid = 0;
    seen_timeout = 0;
    step(6);
    check("mr_no_strobe", seen_valid + seen_timeout, 0);
    check("mr_idle", busy, 0);

    // Four results after reset: raw, raw, raw, then mean of four when averaging.
    begin_meas();
    echo_pulse(10, 1'b0, 10);
    wait_idle();
    begin_meas();
    echo_pulse(20, 1'b0, 20);
    wait_idle();
    begin_meas();
    echo_pulse(30, 1'b0, 30);
    wait_idle();
    begin_meas();
`ifdef ULTRASONIDO_AVG_EN
    echo_pulse(41, 1'b0, 25);
`else
    echo_pulse(41, 1'b0, 41);
`endif
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
